// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID pipeline register.
//
// Keeps the fetch PC and issues in-order requests to a variable-latency instruction
// memory. Returned words land in a small {pc, instr} FIFO whose head drives IF/ID.
// A branch redirect from ID flushes the FIFO, restarts fetch at the new target and
// drops every response that was still in flight. Empty output is a 0/0 bubble.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               enables new fetch requests
//   stall_i               IF/ID hold; head entry is not consumed
//   redirect_i            branch taken in ID; redirect_pc_i is the new target
//   imem_req_o/addr_o     request valid and address (current fetch PC)
//   imem_ready_i          memory accepts the request this cycle
//   imem_rvalid_i/rdata_i in-order response
//   pc_o, instr_o, valid_o  FIFO head toward IF/ID (0/0 when not valid)

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    localparam int unsigned PtrW = $clog2(BUF_DEPTH);
    localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

    typedef logic [CntW-1:0] cnt_t;
    typedef logic [PtrW-1:0] ptr_t;

    localparam logic [CntW:0] DepthC = BUF_DEPTH[CntW:0];

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    cnt_t        outstanding_q, outstanding_d;
    cnt_t        discard_q, discard_d;
    cnt_t        count_q, count_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    ptr_t        wr_ptr_q, wr_ptr_d;

    logic [31:0] buf_pc_q    [BUF_DEPTH];
    logic [31:0] buf_instr_q [BUF_DEPTH];

    logic [CntW:0] credit_used;
    logic          accept;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_target;

    // Outstanding fetches plus buffered words never exceed the FIFO depth, so every
    // response that is kept always has a free slot.
    assign credit_used     = {1'b0, outstanding_q} + {1'b0, count_q};
    assign redirect_target = {redirect_pc_i[31:2], 2'b00};

    always_comb begin
        imem_req_o  = start_i & ~redirect_i & (credit_used < DepthC);
        imem_addr_o = fetch_pc_q;
        accept      = imem_req_o & imem_ready_i;
        // A response in the redirect cycle is stale by definition and is dropped.
        push        = imem_rvalid_i & ~redirect_i & (discard_q == '0);
        valid_o     = (count_q != '0);
        pop         = valid_o & ~stall_i & ~redirect_i;
        pc_o        = valid_o ? buf_pc_q[rd_ptr_q] : 32'h0;
        instr_o     = valid_o ? buf_instr_q[rd_ptr_q] : 32'h0;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + cnt_t'(accept) - cnt_t'(imem_rvalid_i);
        discard_d     = discard_q;
        count_d       = count_q + cnt_t'(push) - cnt_t'(pop);
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = wr_ptr_q + ptr_t'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
        if (imem_rvalid_i && (discard_q != '0)) begin
            discard_d = discard_q - cnt_t'(1);
        end

        if (redirect_i) begin
            fetch_pc_d = redirect_target;
            resp_pc_d  = redirect_target;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            // Everything still in flight after this cycle belongs to the old path.
            discard_d  = outstanding_q - cnt_t'(imem_rvalid_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Payload storage needs no reset: an entry is only read while count_q covers it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_pc_q[wr_ptr_q]    <= resp_pc_q;
            buf_instr_q[wr_ptr_q] <= imem_rdata_i;
        end
    end

endmodule
